// File: rtl/unidade_controle_pkg.sv
// Shared types and codes for the multicycle MIPS-subset control unit:
// state encoding, instruction fields, mux select codes and ALU operations.
package pkg_controle;

    // Control states. FETCH is encoded as zero so the debug state output
    // also reads zero while reset is held.
    typedef enum logic [4:0] {
        ST_FETCH    = 5'd0,
        ST_DECODE   = 5'd1,
        ST_EXEC_R   = 5'd2,
        ST_EXEC_I   = 5'd3,
        ST_WB_ALU   = 5'd4,
        ST_MEM_ADDR = 5'd5,
        ST_MEM_WR   = 5'd6,
        ST_MEM_RD   = 5'd7,
        ST_WB_MEM   = 5'd8,
        ST_WB_SHIFT = 5'd9,
        ST_WB_HI    = 5'd10,
        ST_WB_LO    = 5'd11,
        ST_WB_LUI   = 5'd12,
        ST_BRANCH   = 5'd13,
        ST_JUMP     = 5'd14,
        ST_JR       = 5'd15,
        ST_JAL      = 5'd16,
        ST_EXC_EPC  = 5'd17,
        ST_EXC_JMP  = 5'd18
    } estado_t;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // Writeback mux selects (code 7 is never produced)
    typedef enum logic [2:0] {
        SWB_ALUOUT = 3'd0,
        SWB_MDR    = 3'd1,
        SWB_HI     = 3'd2,
        SWB_LO     = 3'd3,
        SWB_SHIFT  = 3'd4,
        SWB_LUI    = 3'd5,
        SWB_PC     = 3'd6
    } sel_wb_t;

    // PC source mux selects (code 7 is never produced)
    typedef enum logic [2:0] {
        SPC_ALU     = 3'd0,
        SPC_ALUOUT  = 3'd1,
        SPC_JUMP    = 3'd2,
        SPC_RS      = 3'd3,
        SPC_VEC_OPC = 3'd4,
        SPC_VEC_OVF = 3'd5,
        SPC_EPC     = 3'd6
    } sel_pc_t;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    // ALU operand B sources
    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // Register file destination selects
    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    // Exception cause held between EXC_EPC and EXC_JMP
    localparam logic CAUSE_OPCODE = 1'b0;
    localparam logic CAUSE_OVF    = 1'b1;

    // Dispatch target from DECODE; unknown opcodes or R-type functs trap.
    function automatic estado_t despacho(input logic [5:0] op, input logic [5:0] fn);
        estado_t s;
        s = ST_EXC_EPC;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_SLT: s = ST_EXEC_R;
                    FN_SLL, FN_SRL:                 s = ST_WB_SHIFT;
                    FN_MFHI:                        s = ST_WB_HI;
                    FN_MFLO:                        s = ST_WB_LO;
                    FN_JR:                          s = ST_JR;
                    default:                        s = ST_EXC_EPC;
                endcase
            end
            OP_ADDI:       s = ST_EXEC_I;
            OP_LW, OP_SW:  s = ST_MEM_ADDR;
            OP_BEQ, OP_BNE: s = ST_BRANCH;
            OP_LUI:        s = ST_WB_LUI;
            OP_J:          s = ST_JUMP;
            OP_JAL:        s = ST_JAL;
            default:       s = ST_EXC_EPC;
        endcase
        return s;
    endfunction

    // Instructions whose result is discarded on signed overflow
    function automatic logic checa_overflow(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_ADDI) ||
               ((op == OP_RTYPE) && ((fn == FN_ADD) || (fn == FN_SUB)));
    endfunction

endpackage

// File: rtl/unidade_controle_contador_espera.sv
// Memory wait counter: counts 0..MEM_LAT-1 and holds there, flags the last
// cycle, and restarts from zero whenever the control state changes.
module contador_espera #(
    parameter int MEM_LAT = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic done_o
);

    localparam logic [2:0] ULTIMO = 3'(MEM_LAT - 1);

    logic [2:0] count_q;
    logic [2:0] count_d;

    // Next count: clear wins, otherwise advance until the last wait cycle
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 3'd0;
        end else if (count_q != ULTIMO) begin
            count_d = count_q + 3'd1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == ULTIMO);

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control FSM for the 32-bit MIPS-subset datapath. Drives the
// datapath enables and mux selects for fetch, decode, execute, memory,
// writeback and exception entry.
//
// Outputs are decoded from the state and the wait counter. The only
// input-qualified outputs are the branch PC load (zero flag) and the
// WB_ALU register write (suppressed by overflow); both flags come from the
// ALU recomputing on held operands, so they are stable within the cycle.
// While reset is asserted every output is forced to zero.
module unidade_controle
    import pkg_controle::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_wr,
    output logic       i_or_d,
    output logic       mdr_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       aluout_write,
    output logic       epc_write,
    output logic [2:0] sel_wb,
    output logic [2:0] sel_pc,
    output logic [4:0] estado
);

    estado_t state_q, state_d;
    logic    cause_q, cause_d;
    logic    espera_fim;
    logic    ovf_trap;

    // Wait counter restarts on every state change
    contador_espera #(
        .MEM_LAT (MEM_LAT)
    ) u_contador (
        .clk_i   (clk),
        .reset_i (reset),
        .clear_i (state_d != state_q),
        .done_o  (espera_fim)
    );

    assign ovf_trap = overflow && checa_overflow(opcode, funct);

    // Next-state, exception cause and datapath control decode
    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        mem_wr       = 1'b0;
        i_or_d       = 1'b0;
        mdr_write    = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = DST_RT;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_REG;
        alu_op       = ALU_ADD;
        aluout_write = 1'b0;
        epc_write    = 1'b0;
        sel_wb       = SWB_ALUOUT;
        sel_pc       = SPC_ALU;

        case (state_q)
            ST_FETCH: begin
                // PC+4 computed every fetch cycle; loaded with IR on the last
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                if (espera_fim) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    sel_pc   = SPC_ALU;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Branch target speculatively computed into ALUOut
                alu_src_b    = SRCB_IMM_SH;
                aluout_write = 1'b1;
                state_d      = despacho(opcode, funct);
                if (state_d == ST_EXC_EPC) begin
                    cause_d = CAUSE_OPCODE;
                end
            end
            ST_EXEC_R: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_REG;
                aluout_write = 1'b1;
                case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
                state_d = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                alu_op       = ALU_ADD;
                aluout_write = 1'b1;
                state_d      = ST_WB_ALU;
            end
            ST_WB_ALU: begin
                if (ovf_trap) begin
                    cause_d = CAUSE_OVF;
                    state_d = ST_EXC_EPC;
                end else begin
                    reg_write = 1'b1;
                    sel_wb    = SWB_ALUOUT;
                    reg_dst   = (opcode == OP_RTYPE) ? DST_RD : DST_RT;
                    state_d   = ST_FETCH;
                end
            end
            ST_MEM_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                alu_op       = ALU_ADD;
                aluout_write = 1'b1;
                state_d      = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_WR: begin
                i_or_d  = 1'b1;
                mem_wr  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_MEM_RD: begin
                i_or_d = 1'b1;
                if (espera_fim) begin
                    mdr_write = 1'b1;
                    state_d   = ST_WB_MEM;
                end
            end
            ST_WB_MEM: begin
                reg_write = 1'b1;
                sel_wb    = SWB_MDR;
                reg_dst   = DST_RT;
                state_d   = ST_FETCH;
            end
            ST_WB_SHIFT: begin
                reg_write = 1'b1;
                sel_wb    = SWB_SHIFT;
                reg_dst   = DST_RD;
                state_d   = ST_FETCH;
            end
            ST_WB_HI: begin
                reg_write = 1'b1;
                sel_wb    = SWB_HI;
                reg_dst   = DST_RD;
                state_d   = ST_FETCH;
            end
            ST_WB_LO: begin
                reg_write = 1'b1;
                sel_wb    = SWB_LO;
                reg_dst   = DST_RD;
                state_d   = ST_FETCH;
            end
            ST_WB_LUI: begin
                reg_write = 1'b1;
                sel_wb    = SWB_LUI;
                reg_dst   = DST_RT;
                state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
                // rs - rt sets zero; target already sits in ALUOut
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_op    = ALU_SUB;
                sel_pc    = SPC_ALUOUT;
                pc_write  = (opcode == OP_BNE) ? ~zero : zero;
                state_d   = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write = 1'b1;
                sel_pc   = SPC_JUMP;
                state_d  = ST_FETCH;
            end
            ST_JR: begin
                pc_write = 1'b1;
                sel_pc   = SPC_RS;
                state_d  = ST_FETCH;
            end
            ST_JAL: begin
                // PC already holds the return address (PC+4)
                reg_write = 1'b1;
                sel_wb    = SWB_PC;
                reg_dst   = DST_RA;
                state_d   = ST_JUMP;
            end
            ST_EXC_EPC: begin
                // EPC <= PC - 4, the address of the faulting instruction
                alu_src_a = 1'b0;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_SUB;
                epc_write = 1'b1;
                state_d   = ST_EXC_JMP;
            end
            ST_EXC_JMP: begin
                pc_write = 1'b1;
                sel_pc   = (cause_q == CAUSE_OVF) ? SPC_VEC_OVF : SPC_VEC_OPC;
                state_d  = ST_FETCH;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (reset) begin
            pc_write     = 1'b0;
            ir_write     = 1'b0;
            mem_wr       = 1'b0;
            i_or_d       = 1'b0;
            mdr_write    = 1'b0;
            reg_write    = 1'b0;
            reg_dst      = 2'd0;
            alu_src_a    = 1'b0;
            alu_src_b    = 2'd0;
            alu_op       = 3'd0;
            aluout_write = 1'b0;
            epc_write    = 1'b0;
            sel_wb       = 3'd0;
            sel_pc       = 3'd0;
        end
    end

    // State and exception cause registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            cause_q <= CAUSE_OPCODE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    assign estado = state_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed testbench for unidade_controle with MEM_LAT=2. Every task starts
// mid-cycle in FETCH cycle 1 and leaves the DUT mid-cycle in the next FETCH
// cycle 1. Cycle numbering matches the instruction timeline (cycle 1 = first
// FETCH cycle).
module tb_unidade_controle;
    import pkg_controle::*;

    localparam int LAT = 2;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_wr;
        logic       i_or_d;
        logic       mdr_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       aluout_write;
        logic       epc_write;
        logic [2:0] sel_wb;
        logic [2:0] sel_pc;
        logic [4:0] estado;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       overflow = 1'b0;
    logic       pc_write, ir_write, mem_wr, i_or_d, mdr_write, reg_write;
    logic [1:0] reg_dst, alu_src_b;
    logic       alu_src_a, aluout_write, epc_write;
    logic [2:0] alu_op, sel_wb, sel_pc;
    logic [4:0] estado;

    int checks = 0;
    int failures = 0;
    outs_t exp_q[$];

    unidade_controle #(.MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow),
        .pc_write(pc_write), .ir_write(ir_write), .mem_wr(mem_wr),
        .i_or_d(i_or_d), .mdr_write(mdr_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .aluout_write(aluout_write), .epc_write(epc_write),
        .sel_wb(sel_wb), .sel_pc(sel_pc), .estado(estado)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic outs_t snap();
        outs_t s;
        s.pc_write = pc_write; s.ir_write = ir_write; s.mem_wr = mem_wr;
        s.i_or_d = i_or_d; s.mdr_write = mdr_write; s.reg_write = reg_write;
        s.reg_dst = reg_dst; s.alu_src_a = alu_src_a; s.alu_src_b = alu_src_b;
        s.alu_op = alu_op; s.aluout_write = aluout_write; s.epc_write = epc_write;
        s.sel_wb = sel_wb; s.sel_pc = sel_pc; s.estado = estado;
        return s;
    endfunction

    function automatic outs_t base(input estado_t s);
        outs_t e;
        e = '0;
        e.estado = s;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected FETCH cycles followed by DECODE
    task automatic push_fetch_decode();
        outs_t e;
        for (int i = 0; i < LAT; i++) begin
            e = base(ST_FETCH);
            e.alu_src_b = 2'd1;
            if (i == LAT - 1) begin
                e.ir_write = 1'b1;
                e.pc_write = 1'b1;
            end
            exp_q.push_back(e);
        end
        e = base(ST_DECODE);
        e.alu_src_b = 2'd3;
        e.aluout_write = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        outs_t e;
        reset = 1'b1;
        opcode = OP_LW;
        repeat (3) step();
        e = base(ST_FETCH);
        checks++;
        if (snap() !== e) begin
            $display("FAIL reset_hold: got %h expected %h", snap(), e);
            failures++;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_add();
        outs_t e;
        opcode = OP_RTYPE; funct = FN_ADD; zero = 1'b0; overflow = 1'b0;
        push_fetch_decode();
        e = base(ST_EXEC_R); e.alu_src_a = 1'b1; e.aluout_write = 1'b1; exp_q.push_back(e);
        e = base(ST_WB_ALU); e.reg_write = 1'b1; e.reg_dst = 2'd1; exp_q.push_back(e);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            checks++;
            if (snap() !== e) begin
                $display("FAIL add cycle %0d: got %h expected %h", i + 1, snap(), e);
                failures++;
            end
        end
        step();
    endtask

    task automatic test_lw();
        outs_t e;
        opcode = OP_LW; funct = 6'h15; overflow = 1'b0;
        push_fetch_decode();
        e = base(ST_MEM_ADDR); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.aluout_write = 1'b1; exp_q.push_back(e);
        e = base(ST_MEM_RD); e.i_or_d = 1'b1; exp_q.push_back(e);
        e.mdr_write = 1'b1; exp_q.push_back(e);
        e = base(ST_WB_MEM); e.reg_write = 1'b1; e.sel_wb = 3'd1; exp_q.push_back(e);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            checks++;
            if (snap() !== e) begin
                $display("FAIL lw cycle %0d: got %h expected %h", i + 1, snap(), e);
                failures++;
            end
        end
        step();
    endtask

    task automatic test_sw();
        outs_t e;
        opcode = OP_SW; funct = 6'h00;
        push_fetch_decode();
        e = base(ST_MEM_ADDR); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.aluout_write = 1'b1; exp_q.push_back(e);
        e = base(ST_MEM_WR); e.i_or_d = 1'b1; e.mem_wr = 1'b1; exp_q.push_back(e);
        e = base(ST_FETCH); e.alu_src_b = 2'd1; exp_q.push_back(e);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            checks++;
            if (snap() !== e) begin
                $display("FAIL sw cycle %0d: got %h expected %h", i + 1, snap(), e);
                failures++;
            end
        end
    endtask

    // beq and bne both with zero=1: taken only for beq
    task automatic test_branch();
        outs_t e;
        logic [5:0] ops[2];
        ops[0] = OP_BEQ; ops[1] = OP_BNE;
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k]; funct = 6'h2A; zero = 1'b1;
            push_fetch_decode();
            e = base(ST_BRANCH); e.alu_src_a = 1'b1; e.alu_op = 3'd1; e.sel_pc = 3'd1;
            e.pc_write = (k == 0);
            exp_q.push_back(e);
            for (int i = 0; exp_q.size() > 0; i++) begin
                e = exp_q.pop_front();
                if (i > 0) step();
                checks++;
                if (snap() !== e) begin
                    $display("FAIL branch op=%h cycle %0d: got %h expected %h", ops[k], i + 1, snap(), e);
                    failures++;
                end
            end
            step();
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        outs_t e;
        opcode = OP_JAL; funct = 6'h08;
        push_fetch_decode();
        e = base(ST_JAL); e.reg_write = 1'b1; e.sel_wb = 3'd6; e.reg_dst = 2'd2; exp_q.push_back(e);
        e = base(ST_JUMP); e.pc_write = 1'b1; e.sel_pc = 3'd2; exp_q.push_back(e);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            checks++;
            if (snap() !== e) begin
                $display("FAIL jal cycle %0d: got %h expected %h", i + 1, snap(), e);
                failures++;
            end
        end
        step();
    endtask

    // addi with overflow: WB_ALU suppresses the write, then the trap sequence
    task automatic test_addi_overflow();
        outs_t e;
        opcode = OP_ADDI; funct = 6'h20; overflow = 1'b1;
        push_fetch_decode();
        e = base(ST_EXEC_I); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.aluout_write = 1'b1; exp_q.push_back(e);
        e = base(ST_WB_ALU); exp_q.push_back(e);
        e = base(ST_EXC_EPC); e.alu_src_b = 2'd1; e.alu_op = 3'd1; e.epc_write = 1'b1; exp_q.push_back(e);
        e = base(ST_EXC_JMP); e.pc_write = 1'b1; e.sel_pc = 3'd5; exp_q.push_back(e);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            checks++;
            if (snap() !== e) begin
                $display("FAIL addi_ovf cycle %0d: got %h expected %h", i + 1, snap(), e);
                failures++;
            end
        end
        step();
        overflow = 1'b0;
    endtask

    task automatic test_bad_opcode();
        outs_t e;
        opcode = 6'h3F; funct = 6'h20;
        push_fetch_decode();
        e = base(ST_EXC_EPC); e.alu_src_b = 2'd1; e.alu_op = 3'd1; e.epc_write = 1'b1; exp_q.push_back(e);
        e = base(ST_EXC_JMP); e.pc_write = 1'b1; e.sel_pc = 3'd4; exp_q.push_back(e);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            if (i > 0) step();
            checks++;
            if (snap() !== e) begin
                $display("FAIL bad_opcode cycle %0d: got %h expected %h", i + 1, snap(), e);
                failures++;
            end
        end
        step();
    endtask

    // R-type ALU ops: per-funct ALU code; 'and' ignores the overflow flag
    task automatic test_r_alu_ops();
        outs_t e;
        logic [5:0] fns[3];
        logic [2:0] ops[3];
        fns[0] = FN_SUB; ops[0] = 3'd1;
        fns[1] = FN_AND; ops[1] = 3'd2;
        fns[2] = FN_SLT; ops[2] = 3'd3;
        for (int k = 0; k < 3; k++) begin
            opcode = OP_RTYPE; funct = fns[k]; overflow = (k != 0);
            push_fetch_decode();
            e = base(ST_EXEC_R); e.alu_src_a = 1'b1; e.alu_op = ops[k]; e.aluout_write = 1'b1; exp_q.push_back(e);
            e = base(ST_WB_ALU); e.reg_write = 1'b1; e.reg_dst = 2'd1; exp_q.push_back(e);
            for (int i = 0; exp_q.size() > 0; i++) begin
                e = exp_q.pop_front();
                if (i > 0) step();
                checks++;
                if (snap() !== e) begin
                    $display("FAIL r_alu funct=%h cycle %0d: got %h expected %h", fns[k], i + 1, snap(), e);
                    failures++;
                end
            end
            step();
        end
        overflow = 1'b0;
    endtask

    // Single-cycle writebacks and jr
    task automatic test_short_ops();
        outs_t e;
        logic [5:0] opv[5];
        logic [5:0] fnv[5];
        opv[0] = OP_RTYPE; fnv[0] = FN_SRL;
        opv[1] = OP_RTYPE; fnv[1] = FN_MFHI;
        opv[2] = OP_RTYPE; fnv[2] = FN_MFLO;
        opv[3] = OP_LUI;   fnv[3] = 6'h00;
        opv[4] = OP_RTYPE; fnv[4] = FN_JR;
        for (int k = 0; k < 5; k++) begin
            opcode = opv[k]; funct = fnv[k];
            push_fetch_decode();
            case (k)
                0: begin e = base(ST_WB_SHIFT); e.reg_write = 1'b1; e.sel_wb = 3'd4; e.reg_dst = 2'd1; end
                1: begin e = base(ST_WB_HI);    e.reg_write = 1'b1; e.sel_wb = 3'd2; e.reg_dst = 2'd1; end
                2: begin e = base(ST_WB_LO);    e.reg_write = 1'b1; e.sel_wb = 3'd3; e.reg_dst = 2'd1; end
                3: begin e = base(ST_WB_LUI);   e.reg_write = 1'b1; e.sel_wb = 3'd5; e.reg_dst = 2'd0; end
                default: begin e = base(ST_JR); e.pc_write = 1'b1; e.sel_pc = 3'd3; end
            endcase
            exp_q.push_back(e);
            for (int i = 0; exp_q.size() > 0; i++) begin
                e = exp_q.pop_front();
                if (i > 0) step();
                checks++;
                if (snap() !== e) begin
                    $display("FAIL short op=%h funct=%h cycle %0d: got %h expected %h", opv[k], fnv[k], i + 1, snap(), e);
                    failures++;
                end
            end
            step();
        end
    endtask

    // Reset in the middle of MEM_RD, then a full lw from a clean fetch
    task automatic test_reset_mid_memrd();
        outs_t e;
        opcode = OP_LW; funct = 6'h00;
        repeat (4) step();
        e = base(ST_MEM_RD); e.i_or_d = 1'b1;
        checks++;
        if (snap() !== e) begin
            $display("FAIL pre_reset_memrd: got %h expected %h", snap(), e);
            failures++;
        end
        reset = 1'b1;
        #1;
        e = base(ST_FETCH);
        checks++;
        if (snap() !== e) begin
            $display("FAIL reset_mid_memrd: got %h expected %h", snap(), e);
            failures++;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        test_lw();
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw();
        test_sw();
        test_branch();
        test_jal();
        test_addi_overflow();
        test_bad_opcode();
        test_r_alu_ops();
        test_short_ops();
        test_reset_mid_memrd();
        test_add();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
